// File: rtl/key_bounce_gen_pkg.sv
// Shared definitions for the bouncing-key generator: FSM encodings, LFSR constants and defaults.
// Debouncer benches import the same package so both sides agree on timing and sequence.
package key_bounce_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE           = 2'd0,
    ST_PRESS_BOUNCE   = 2'd1,
    ST_HOLD           = 2'd2,
    ST_RELEASE_BOUNCE = 2'd3
  } key_state_t;

  localparam int          LFSR_W           = 16;
  localparam logic [15:0] DEF_LFSR_SEED    = 16'hACE1;
  localparam logic [21:0] DEF_CNT_BOUNCE   = 22'd499_999;
  localparam logic [21:0] DEF_CNT_HOLD     = 22'd1_999_999;

  // Fibonacci taps 16,14,13,11 in right-shift form; the feedback enters at the MSB.
  function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/key_bounce_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR that supplies the bounce noise.
// It advances on every clock edge and reloads SEED on reset.
module lfsr16
  import key_bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SEED;
    else        r_state <= lfsrNext(r_state);
  end

  assign o_state = r_state;

endmodule

// File: rtl/key_bounce_gen.sv
// Emulates one mechanical key press per press_req: noisy press, stable-low hold,
// noisy release, then stable high with a one-cycle done pulse.
module key_bounce_gen
  import key_bounce_gen_pkg::*;
#(
  parameter logic [21:0] CNT_BOUNCE = DEF_CNT_BOUNCE,
  parameter logic [21:0] CNT_HOLD   = DEF_CNT_HOLD,
  parameter logic [15:0] LFSR_SEED  = DEF_LFSR_SEED
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic press_req,
  output logic key_out,
  output logic busy,
  output logic done
);

  key_state_t  r_state;
  key_state_t  w_nextState;
  logic [21:0] r_cnt;
  logic [21:0] w_nextCnt;
  logic        r_keyOut;
  logic        w_nextKey;
  logic        r_done;
  logic        w_nextDone;
  logic [15:0] w_lfsr;
  logic        w_noise;
  logic [14:0] w_unusedLfsr;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .o_state(w_lfsr)
  );

  assign w_noise      = w_lfsr[0];
  assign w_unusedLfsr = w_lfsr[15:1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_keyOut <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_cnt    <= w_nextCnt;
      r_keyOut <= w_nextKey;
      r_done   <= w_nextDone;
    end
  end

  // The counter restarts at zero on every state entry and stops at its terminal value.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextKey   = r_keyOut;
    w_nextDone  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nextKey = 1'b1;
        w_nextCnt = '0;
        if (press_req) begin
          w_nextState = ST_PRESS_BOUNCE;
          w_nextKey   = 1'b0;
        end
      end
      ST_PRESS_BOUNCE: begin
        if (r_cnt == CNT_BOUNCE) begin
          w_nextState = ST_HOLD;
          w_nextKey   = 1'b0;
          w_nextCnt   = '0;
        end else begin
          w_nextKey = w_noise;
          w_nextCnt = r_cnt + 22'd1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == CNT_HOLD) begin
          w_nextState = ST_RELEASE_BOUNCE;
          w_nextKey   = 1'b1;
          w_nextCnt   = '0;
        end else begin
          w_nextKey = 1'b0;
          w_nextCnt = r_cnt + 22'd1;
        end
      end
      ST_RELEASE_BOUNCE: begin
        if (r_cnt == CNT_BOUNCE) begin
          w_nextState = ST_IDLE;
          w_nextKey   = 1'b1;
          w_nextCnt   = '0;
          w_nextDone  = 1'b1;
        end else begin
          w_nextKey = w_noise;
          w_nextCnt = r_cnt + 22'd1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextKey   = 1'b1;
        w_nextCnt   = '0;
      end
    endcase
  end

  assign key_out = r_keyOut;
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Scoreboard bench for key_bounce_gen with short bounce/hold windows.
// The stimulus side pushes the expected outputs per cycle; a negedge monitor pops and compares.
module tb_key_bounce_gen;

  localparam int          CB   = 9;
  localparam int          CH   = 49;
  localparam int          LAST = 2 * CB + CH + 3;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    logic key;
    logic busy;
    logic done;
    int   k;
  } exp_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic press_req = 1'b0;
  logic key_out;
  logic busy;
  logic done;

  exp_t        expQ[$];
  int          checks       = 0;
  int          errors       = 0;
  int          doneSeen     = 0;
  int          doneExpected = 0;
  int          tbK          = -1;
  logic [15:0] tbLfsr       = SEED;

  key_bounce_gen #(
    .CNT_BOUNCE(22'd9),
    .CNT_HOLD  (22'd49),
    .LFSR_SEED (SEED)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .press_req(press_req),
    .key_out  (key_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic pushExp(input logic key, input logic bsy, input logic dn, input int k);
    exp_t e;
    e.key  = key;
    e.busy = bsy;
    e.done = dn;
    e.k    = k;
    expQ.push_back(e);
  endtask

  // One clock edge: drive the request, then derive what the outputs must be after that edge
  // from the press timeline (k = edge index since the accepted request).
  task automatic applyStimulus(input logic req);
    logic lb;
    press_req = req;
    @(posedge sys_clk);
    lb     = tbLfsr[0];
    tbLfsr = lfsrStep(tbLfsr);
    if (tbK < 0) begin
      if (req) tbK = 0;
    end else begin
      tbK++;
    end
    if (tbK < 0)                  pushExp(1'b1, 1'b0, 1'b0, tbK);
    else if (tbK == 0)            pushExp(1'b0, 1'b1, 1'b0, tbK);
    else if (tbK <= CB)           pushExp(lb,   1'b1, 1'b0, tbK);
    else if (tbK <= CB + CH + 1)  pushExp(1'b0, 1'b1, 1'b0, tbK);
    else if (tbK == CB + CH + 2)  pushExp(1'b1, 1'b1, 1'b0, tbK);
    else if (tbK < LAST)          pushExp(lb,   1'b1, 1'b0, tbK);
    else begin
      pushExp(1'b1, 1'b0, 1'b1, tbK);
      doneExpected++;
      tbK = -1;
    end
    #1;
  endtask

  // Reset lands 2 ns after an edge and is checked at the following negedge,
  // so the outputs must change without any clock edge in between.
  task automatic applyReset();
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    tbK    = -1;
    tbLfsr = SEED;
    pushExp(1'b1, 1'b0, 1'b0, -2);
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (key_out !== e.key || busy !== e.busy || done !== e.done) begin
      errors++;
      $display("[TB] FAIL outputs k=%0d at %0t: key/busy/done actual %b%b%b required %b%b%b",
               e.k, $time, key_out, busy, done, e.key, e.busy, e.done);
    end
  endtask

  always @(negedge sys_clk) begin
    if (done === 1'b1) doneSeen++;
    if (expQ.size() != 0) checkOutput(expQ.pop_front());
  end

  initial begin
    pushExp(1'b1, 1'b0, 1'b0, -2);
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;

    $display("[TB] idle after reset");
    repeat (100) applyStimulus(1'b0);

    $display("[TB] single press");
    repeat (5) applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (LAST + 4) applyStimulus(1'b0);

    $display("[TB] requests during a press are ignored");
    applyStimulus(1'b1);
    for (int k = 1; k <= LAST + 4; k++) applyStimulus(k == 5 || k == 30 || k == 65);

    $display("[TB] back-to-back presses");
    repeat (2 * (LAST + 1)) applyStimulus(1'b1);
    repeat (5) applyStimulus(1'b0);

    $display("[TB] reset during hold, then reseeded press");
    applyReset();
    repeat (5) applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (30) applyStimulus(1'b0);
    applyReset();
    repeat (5) applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (LAST + 4) applyStimulus(1'b0);

    @(negedge sys_clk);
    #1;
    checks++;
    if (doneSeen != doneExpected) begin
      errors++;
      $display("[TB] FAIL done_count actual %0d required %0d", doneSeen, doneExpected);
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual %0d pending required 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
